// File: rtl/mux_nto1_stream_if.sv
// Channel bank, select control and valid/ready output bundle for mux_nto1_stream.
// scan_wrap exists only when MUX_SCAN_EN is defined.
interface mux_nto1_stream_if #(
  parameter int unsigned NUM_IN = 7,
  parameter int unsigned DATA_W = 1,
  parameter int unsigned SEL_W  = 3
);
  logic [NUM_IN*DATA_W-1:0] in;
  logic [SEL_W-1:0]         sel_in;
  logic                     sel_load;
  logic                     en;
  logic                     scan_en;
  logic                     out_ready;
  logic [DATA_W-1:0]        out_data;
  logic                     out_valid;
  logic                     sel_err;
  logic [SEL_W-1:0]         cur_sel;
`ifdef MUX_SCAN_EN
  logic                     scan_wrap;
`endif

  modport master (
    output in,
    output sel_in,
    output sel_load,
    output en,
    output scan_en,
    output out_ready,
    input  out_data,
    input  out_valid,
    input  sel_err,
`ifdef MUX_SCAN_EN
    input  scan_wrap,
`endif
    input  cur_sel
  );

  modport slave (
    input  in,
    input  sel_in,
    input  sel_load,
    input  en,
    input  scan_en,
    input  out_ready,
    output out_data,
    output out_valid,
    output sel_err,
`ifdef MUX_SCAN_EN
    output scan_wrap,
`endif
    output cur_sel
  );
endinterface

// File: rtl/mux_nto1_stream.sv
// Registered N-to-1 channel selector with a select register and valid/ready output.
// Define MUX_SCAN_EN to enable auto-scan of the select register and the scan_wrap pulse.
module mux_nto1_stream #(
  parameter int unsigned       NUM_IN  = 7,
  parameter int unsigned       DATA_W  = 1,
  parameter int unsigned       SEL_W   = 3,
  parameter logic [DATA_W-1:0] OOR_VAL = '0
) (
  input logic              clk,
  input logic              rst,
  mux_nto1_stream_if.slave bus
);

  localparam logic [SEL_W-1:0] LastSel = SEL_W'(NUM_IN - 1);

  logic [SEL_W-1:0]  sel_q, sel_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              err_q, err_d;
  logic              cap;
  logic              scan_step;
  logic [DATA_W-1:0] sample;
  logic              sample_oor;
`ifdef MUX_SCAN_EN
  logic              wrap_q, wrap_d;
`else
  logic              unused_scan_en;
  assign unused_scan_en = bus.scan_en;
`endif

  assign cap = bus.en & (~valid_q | bus.out_ready);

  // Matching against every legal index avoids reading past the packed bus when sel_q >= NUM_IN.
  always_comb begin
    sample     = OOR_VAL;
    sample_oor = 1'b1;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (sel_q == SEL_W'(k)) begin
        sample     = bus.in[k*DATA_W +: DATA_W];
        sample_oor = 1'b0;
      end
    end
  end

  always_comb begin
    data_d  = data_q;
    err_d   = err_q;
    valid_d = valid_q;
    if (cap) begin
      data_d  = sample;
      err_d   = sample_oor;
      valid_d = 1'b1;
    end else if (valid_q && bus.out_ready) begin
      valid_d = 1'b0;
    end
  end

  always_comb begin
`ifdef MUX_SCAN_EN
    scan_step = bus.scan_en & cap;
    wrap_d    = 1'b0;
`else
    scan_step = 1'b0;
`endif
    sel_d = sel_q;
    if (bus.sel_load) begin
      sel_d = bus.sel_in;
    end else if (scan_step) begin
      sel_d = (sel_q >= LastSel) ? '0 : sel_q + 1'b1;
`ifdef MUX_SCAN_EN
      wrap_d = (sel_q == LastSel);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sel_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
`ifdef MUX_SCAN_EN
      wrap_q  <= 1'b0;
`endif
    end else begin
      sel_q   <= sel_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      err_q   <= err_d;
`ifdef MUX_SCAN_EN
      wrap_q  <= wrap_d;
`endif
    end
  end

  assign bus.out_data  = data_q;
  assign bus.out_valid = valid_q;
  assign bus.sel_err   = err_q;
  assign bus.cur_sel   = sel_q;
`ifdef MUX_SCAN_EN
  assign bus.scan_wrap = wrap_q;
`endif

endmodule

// File: tb/tb_mux_nto1_stream.sv
// Bench for mux_nto1_stream: directed scenarios then random traffic, checked each cycle
// against a per-cycle reference model of the selector.
module tb_mux_nto1_stream;
  localparam int unsigned       NUM_IN  = 7;
  localparam int unsigned       DATA_W  = 3;
  localparam int unsigned       SEL_W   = 3;
  localparam logic [DATA_W-1:0] OOR_VAL = 3'd5;
`ifdef MUX_SCAN_EN
  localparam bit SCAN = 1'b1;
`else
  localparam bit SCAN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mux_nto1_stream_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W), .SEL_W(SEL_W)) bus ();

  mux_nto1_stream #(
    .NUM_IN (NUM_IN),
    .DATA_W (DATA_W),
    .SEL_W  (SEL_W),
    .OOR_VAL(OOR_VAL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int chan [NUM_IN];
  int m_sel, m_data, m_valid, m_err, m_wrap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic drive_chans();
    for (int k = 0; k < NUM_IN; k++) bus.in[k*DATA_W +: DATA_W] = chan[k][DATA_W-1:0];
  endtask

  // One clock: advance the model with the inputs seen at the edge, then compare.
  task automatic step();
    bit cap;
    @(posedge clk);
    if (rst) begin
      m_sel = 0; m_data = 0; m_valid = 0; m_err = 0; m_wrap = 0;
    end else begin
      cap    = bus.en && (!m_valid || bus.out_ready);
      m_wrap = 0;
      if (cap) begin
        if (m_sel < NUM_IN) begin
          m_data = chan[m_sel];
          m_err  = 0;
        end else begin
          m_data = OOR_VAL;
          m_err  = 1;
        end
        m_valid = 1;
      end else if (m_valid && bus.out_ready) begin
        m_valid = 0;
      end
      if (bus.sel_load) begin
        m_sel = bus.sel_in;
      end else if (SCAN && bus.scan_en && cap) begin
        m_wrap = (m_sel == NUM_IN - 1) ? 1 : 0;
        m_sel  = (m_sel < NUM_IN - 1) ? m_sel + 1 : 0;
      end
    end
    #1;
    check("out_valid", bus.out_valid, m_valid);
    check("out_data", bus.out_data, m_data);
    check("sel_err", bus.sel_err, m_err);
    check("cur_sel", bus.cur_sel, m_sel);
`ifdef MUX_SCAN_EN
    check("scan_wrap", bus.scan_wrap, m_wrap);
`endif
  endtask

  task automatic load_sel(input int s);
    bus.sel_in   = s[SEL_W-1:0];
    bus.sel_load = 1'b1;
    step();
    bus.sel_load = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.in = '0; bus.sel_in = '0; bus.sel_load = 1'b0;
    bus.en = 1'b0; bus.scan_en = 1'b0; bus.out_ready = 1'b0;
    for (int k = 0; k < NUM_IN; k++) chan[k] = k;
    drive_chans();
    step();
    step();
    check("rst_valid", bus.out_valid, 0);
    check("rst_data", bus.out_data, 0);

    // Manual select sweep
    rst = 1'b0;
    bus.en = 1'b1;
    bus.out_ready = 1'b1;
    for (int s = 0; s < NUM_IN; s++) begin
      load_sel(s);
      step();
      check("manual_data", bus.out_data, s);
      repeat (8) step();
    end

    // Out-of-range select, then recovery
    load_sel(7);
    step();
    check("oor_data", bus.out_data, OOR_VAL);
    check("oor_err", bus.sel_err, 1);
    load_sel(1);
    step();
    check("oor_recover_data", bus.out_data, 1);
    check("oor_recover_err", bus.sel_err, 0);

    // Backpressure while the select and channel data move underneath
    load_sel(3);
    step();
    bus.out_ready = 1'b0;
    load_sel(0);
    chan[3] = 6;
    drive_chans();
    repeat (4) step();
    check("bp_data", bus.out_data, 3);
    check("bp_valid", bus.out_valid, 1);
    chan[3] = 3;
    drive_chans();
    bus.out_ready = 1'b1;
    step();
    check("bp_release_data", bus.out_data, 0);

    // Scan through the wrap, then a mid-scan load
    load_sel(0);
    bus.scan_en = 1'b1;
    repeat (9) step();
    load_sel(4);
    repeat (4) step();
    bus.scan_en = 1'b0;

    // Drain with en low
    bus.en = 1'b0;
    step();
    check("drain_valid", bus.out_valid, 0);
    repeat (3) step();
    bus.en = 1'b1;
    step();

    // Reset mid-stream
    chan[0] = 2;
    drive_chans();
    bus.scan_en = 1'b1;
    repeat (3) step();
    rst = 1'b1;
    step();
    check("midrst_sel", bus.cur_sel, 0);
    check("midrst_valid", bus.out_valid, 0);
    rst = 1'b0;
    step();
    check("midrst_first", bus.out_data, 2);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      rst           = ($urandom_range(0, 99) == 0);
      bus.en        = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.scan_en   = $urandom_range(0, 1);
      bus.sel_load  = ($urandom_range(0, 7) == 0);
      bus.sel_in    = SEL_W'($urandom_range(0, (1 << SEL_W) - 1));
      if ($urandom_range(0, 3) == 0) begin
        for (int k = 0; k < NUM_IN; k++) chan[k] = $urandom_range(0, (1 << DATA_W) - 1);
        drive_chans();
      end
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
